// File: rtl/crack_pkg.sv
// Shared definitions for the key-search datapath: key width, key type and
// the scheduler state encoding used by crack_scheduler.
package crack_pkg;

    localparam int KEY_W = 24;

    typedef logic [KEY_W-1:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_KG   = 3'd2,
        ST_DISPATCH  = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_FOUND     = 3'd5,
        ST_EXHAUSTED = 3'd6
    } sched_state_t;

endpackage

// File: rtl/crack_scheduler_rr_arbiter.sv
// Combinational round-robin picker: returns the first eligible index at or
// after ptr, wrapping. The pointer register itself lives in the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int cand;

    // Scan from ptr upward, wrapping, and keep the first eligible hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!any && eligible[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand[IW-1:0];
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/crack_scheduler.sv
// Brute-force key scheduler: pulls keys from the key generator one at a time
// and hands them round-robin to idle decryption cores, remembering which key
// each core holds so a reported match can be traced back to its key.
module crack_scheduler #(
    parameter int N_CORES = 4,
    parameter int KEY_W   = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       go,
    output logic                       kg_start,
    input  logic                       kg_finished,
    input  logic                       kg_terminated,
    input  logic [KEY_W-1:0]           kg_key,
    input  logic [N_CORES-1:0]         core_req,
    output logic [N_CORES-1:0]         core_grant,
    output logic [KEY_W-1:0]           core_key,
    input  logic [N_CORES-1:0]         core_done,
    input  logic [N_CORES-1:0]         core_match,
    output logic                       core_abort,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [KEY_W-1:0]           found_key,
    output logic [$clog2(N_CORES)-1:0] found_core,
    output logic [KEY_W-1:0]           keys_issued
);

    import crack_pkg::*;

    localparam int               IW       = $clog2(N_CORES);
    localparam logic [IW-1:0]    LAST_IDX = IW'(N_CORES - 1);
    localparam logic [KEY_W-1:0] KEYS_MAX = {KEY_W{1'b1}};

    // Grant counter stops at all-ones instead of wrapping back to zero.
    function automatic logic [KEY_W-1:0] sat_inc(input logic [KEY_W-1:0] v);
        return (v == KEYS_MAX) ? v : v + {{(KEY_W-1){1'b0}}, 1'b1};
    endfunction

    sched_state_t       state_q, state_d;
    logic [N_CORES-1:0] outstanding_q, outstanding_d;
    logic               last_q, last_d;
    logic [KEY_W-1:0]   held_key_q, held_key_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [KEY_W-1:0]   slot_key_q [N_CORES];
    logic [KEY_W-1:0]   slot_key_d [N_CORES];

    logic               kg_start_q, kg_start_d;
    logic [N_CORES-1:0] core_grant_q, core_grant_d;
    logic [KEY_W-1:0]   core_key_q, core_key_d;
    logic               core_abort_q, core_abort_d;
    logic               busy_q, busy_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic [KEY_W-1:0]   found_key_q, found_key_d;
    logic [IW-1:0]      found_core_q, found_core_d;
    logic [KEY_W-1:0]   keys_issued_q, keys_issued_d;

    logic [N_CORES-1:0] eligible_s;
    logic [N_CORES-1:0] arb_grant_s;
    logic [IW-1:0]      arb_idx_s;
    logic               arb_any_s;
    logic [N_CORES-1:0] match_vec_s;
    logic               match_any_s;
    logic [IW-1:0]      match_idx_s;
    logic               searching_s;
    logic               match_hit_s;
    logic               start_s;

    assign eligible_s = core_req & ~outstanding_q;

    rr_arbiter #(
        .N  (N_CORES),
        .IW (IW)
    ) u_arb (
        .eligible  (eligible_s),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .any       (arb_any_s)
    );

    // Lowest-index qualified match among cores that actually hold a key.
    always_comb begin
        match_vec_s = core_done & core_match & outstanding_q;
        match_any_s = 1'b0;
        match_idx_s = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (match_vec_s[i]) begin
                match_any_s = 1'b1;
                match_idx_s = i[IW-1:0];
            end else begin
                match_any_s = match_any_s;
            end
        end
        searching_s = (state_q == ST_FETCH)    || (state_q == ST_WAIT_KG) ||
                      (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
        match_hit_s = searching_s && match_any_s;
    end

    // Next-state, dispatch bookkeeping and status; a match overrides a grant.
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q & ~core_done;
        last_d        = last_q;
        held_key_d    = held_key_q;
        rr_ptr_d      = rr_ptr_q;
        slot_key_d    = slot_key_q;
        core_grant_d  = '0;
        core_key_d    = '0;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        found_key_d   = found_key_q;
        found_core_d  = found_core_q;
        keys_issued_d = keys_issued_q;
        start_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_KG;
            end
            ST_WAIT_KG: begin
                if (kg_finished || kg_terminated) begin
                    held_key_d = kg_key;
                    last_d     = last_q | kg_terminated;
                    state_d    = ST_DISPATCH;
                end else begin
                    state_d = ST_WAIT_KG;
                end
            end
            ST_DISPATCH: begin
                if (arb_any_s && !match_hit_s) begin
                    core_grant_d           = arb_grant_s;
                    core_key_d             = held_key_q;
                    slot_key_d[arb_idx_s]  = held_key_q;
                    outstanding_d          = outstanding_d | arb_grant_s;
                    rr_ptr_d               = (arb_idx_s == LAST_IDX) ? '0 : arb_idx_s + IW'(1);
                    keys_issued_d          = sat_inc(keys_issued_q);
                    state_d                = last_q ? ST_DRAIN : ST_FETCH;
                end else begin
                    state_d = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = ST_EXHAUSTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FOUND: begin
                if (go) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_FOUND;
                end
            end
            ST_EXHAUSTED: begin
                if (go) begin
                    start_s = 1'b1;
                end else begin
                    exhausted_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_s) begin
            state_d       = ST_FETCH;
            outstanding_d = '0;
            last_d        = 1'b0;
            keys_issued_d = '0;
            found_d       = 1'b0;
            exhausted_d   = 1'b0;
            found_key_d   = '0;
            found_core_d  = '0;
        end else if (match_hit_s) begin
            state_d      = ST_FOUND;
            found_d      = 1'b1;
            found_key_d  = slot_key_q[match_idx_s];
            found_core_d = match_idx_s;
        end else begin
            state_d = state_d;
        end

        kg_start_d   = (state_d == ST_FETCH);
        core_abort_d = (state_d == ST_FOUND) || (state_d == ST_EXHAUSTED);
        busy_d       = (state_d != ST_IDLE) && (state_d != ST_FOUND) &&
                       (state_d != ST_EXHAUSTED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            outstanding_q <= '0;
            last_q        <= 1'b0;
            held_key_q    <= '0;
            rr_ptr_q      <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                slot_key_q[i] <= '0;
            end
            kg_start_q    <= 1'b0;
            core_grant_q  <= '0;
            core_key_q    <= '0;
            core_abort_q  <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            found_key_q   <= '0;
            found_core_q  <= '0;
            keys_issued_q <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            last_q        <= last_d;
            held_key_q    <= held_key_d;
            rr_ptr_q      <= rr_ptr_d;
            slot_key_q    <= slot_key_d;
            kg_start_q    <= kg_start_d;
            core_grant_q  <= core_grant_d;
            core_key_q    <= core_key_d;
            core_abort_q  <= core_abort_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            found_key_q   <= found_key_d;
            found_core_q  <= found_core_d;
            keys_issued_q <= keys_issued_d;
        end
    end

    assign kg_start    = kg_start_q;
    assign core_grant  = core_grant_q;
    assign core_key    = core_key_q;
    assign core_abort  = core_abort_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign found_key   = found_key_q;
    assign found_core  = found_core_q;
    assign keys_issued = keys_issued_q;

endmodule

// File: tb/tb_crack_scheduler.sv
// Bench for crack_scheduler: behavioural key generator and core models,
// a grant scoreboard, a table of whole-search scenarios and a few
// hand-written sequences for match, tie-break and mid-search reset.
module tb_crack_scheduler;

    localparam int N_CORES = 4;
    localparam int KEY_W   = 24;
    localparam int GEN_LAT = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              go = 1'b0;
    logic              kg_start;
    logic              kg_finished = 1'b0;
    logic              kg_terminated = 1'b0;
    logic [KEY_W-1:0]  kg_key = '0;
    logic [3:0]        core_req;
    logic [3:0]        core_grant;
    logic [KEY_W-1:0]  core_key;
    logic [3:0]        core_done;
    logic [3:0]        core_match;
    logic              core_abort;
    logic              busy;
    logic              found;
    logic              exhausted;
    logic [KEY_W-1:0]  found_key;
    logic [1:0]        found_core;
    logic [KEY_W-1:0]  keys_issued;

    always #5 clk = ~clk;

    crack_scheduler #(.N_CORES(N_CORES), .KEY_W(KEY_W)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .kg_start(kg_start),
        .kg_finished(kg_finished), .kg_terminated(kg_terminated), .kg_key(kg_key),
        .core_req(core_req), .core_grant(core_grant), .core_key(core_key),
        .core_done(core_done), .core_match(core_match), .core_abort(core_abort),
        .busy(busy), .found(found), .exhausted(exhausted), .found_key(found_key),
        .found_core(found_core), .keys_issued(keys_issued)
    );

    // stimulus configuration (written by the initial block only)
    logic             man_mode = 1'b0;
    logic [3:0]       m_req = '0, m_done = '0, m_match = '0;
    logic [3:0]       req_mask = '0;
    logic             match_en = 1'b0;
    logic [KEY_W-1:0] match_key = '0;
    logic [KEY_W-1:0] gen_lower = '0, gen_upper = '0;

    // model state (written by the model process only)
    logic [3:0]       a_req = '0, a_done = '0, a_match = '0;
    logic [KEY_W-1:0] gen_cur = '0;
    int               gen_cnt = 0;
    logic             kg_prev = 1'b0;
    int               kg_starts = 0;
    logic             c_busy [4];
    int               c_cnt [4];
    logic [KEY_W-1:0] c_key [4];
    int               sb_checks = 0, sb_passes = 0;
    logic [1:0]       gidx;

    typedef struct packed {
        logic [1:0]       core;
        logic [KEY_W-1:0] key;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    assign core_req   = man_mode ? m_req   : a_req;
    assign core_done  = man_mode ? m_done  : a_done;
    assign core_match = man_mode ? m_match : a_match;

    // Models and grant scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        if (reset_n && core_grant != 4'b0000) begin
            gidx = 2'd0;
            for (int i = 0; i < 4; i++) if (core_grant[i]) gidx = i[1:0];
            sb_checks++;
            if ($onehot(core_grant)) sb_passes++;
            else $display("FAIL grant_onehot: got %b, required one-hot", core_grant);
            sb_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_grant: got core %0d key 0x%0h, required no grant", gidx, core_key);
            end else begin
                sb_e = sb_q.pop_front();
                if (gidx == sb_e.core && core_key == sb_e.key) sb_passes++;
                else $display("FAIL grant_order: got core %0d key 0x%0h, required core %0d key 0x%0h",
                              gidx, core_key, sb_e.core, sb_e.key);
            end
        end
        // key generator: fires GEN_LAT falling edges after a kg_start rising edge
        kg_finished   = 1'b0;
        kg_terminated = 1'b0;
        if (!reset_n) begin
            gen_cur = gen_lower;
            gen_cnt = 0;
            kg_prev = 1'b0;
        end else begin
            if (kg_start && !kg_prev) begin
                kg_starts++;
                gen_cnt = GEN_LAT;
            end
            kg_prev = kg_start;
            if (gen_cnt > 0) begin
                gen_cnt--;
                if (gen_cnt == 0) begin
                    kg_key = gen_cur;
                    if (gen_cur == gen_upper) begin
                        kg_terminated = 1'b1;
                        gen_cur = gen_lower;
                    end else begin
                        kg_finished = 1'b1;
                        gen_cur = gen_cur + 24'd1;
                    end
                end
            end
        end
        // cores: report done one cycle after accepting a key
        for (int i = 0; i < 4; i++) begin
            a_done[i]  = 1'b0;
            a_match[i] = 1'b0;
            if (!reset_n || core_abort) begin
                c_busy[i] = 1'b0;
            end else if (core_grant[i]) begin
                c_busy[i] = 1'b1;
                c_key[i]  = core_key;
                c_cnt[i]  = 1;
            end else if (c_busy[i]) begin
                c_cnt[i]--;
                if (c_cnt[i] == 0) begin
                    a_done[i]  = 1'b1;
                    a_match[i] = match_en && (c_key[i] == match_key);
                    c_busy[i]  = 1'b0;
                end
            end
            a_req[i] = req_mask[i] && !c_busy[i];
        end
    end

    int checks = 0, passes = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_status(input int bound);
        int n = 0;
        while (!(found || exhausted) && n < bound) begin
            tick();
            n++;
        end
        check("status_timeout", {127'd0, (found || exhausted)}, 128'd1);
    endtask

    task automatic wait_sb_empty(input int bound);
        int n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("grants_timeout", sb_q.size(), 128'd0);
    endtask

    typedef struct {
        logic [KEY_W-1:0] upper;
        logic [3:0]       mask;
        logic             men;
        logic [KEY_W-1:0] mkey;
        logic             rst;
        logic             go_mid;
        logic             e_found;
        logic [1:0]       e_core;
        logic [KEY_W-1:0] e_fkey;
        logic [KEY_W-1:0] e_issued;
        int               e_kgs;
    } vec_t;

    vec_t vecs [6];
    int   kg_base;
    int   bits[$];
    int   n_grants;

    initial begin
        vecs[0] = '{upper: 24'd3,  mask: 4'b0001, men: 1'b0, mkey: 24'd0, rst: 1'b1, go_mid: 1'b0,
                    e_found: 1'b0, e_core: 2'd0, e_fkey: 24'd0, e_issued: 24'd4, e_kgs: 4};
        vecs[1] = '{upper: 24'd3,  mask: 4'b0001, men: 1'b0, mkey: 24'd0, rst: 1'b0, go_mid: 1'b1,
                    e_found: 1'b0, e_core: 2'd0, e_fkey: 24'd0, e_issued: 24'd4, e_kgs: 4};
        vecs[2] = '{upper: 24'd4,  mask: 4'b1111, men: 1'b0, mkey: 24'd0, rst: 1'b1, go_mid: 1'b0,
                    e_found: 1'b0, e_core: 2'd0, e_fkey: 24'd0, e_issued: 24'd5, e_kgs: 5};
        vecs[3] = '{upper: 24'd7,  mask: 4'b1011, men: 1'b0, mkey: 24'd0, rst: 1'b1, go_mid: 1'b0,
                    e_found: 1'b0, e_core: 2'd0, e_fkey: 24'd0, e_issued: 24'd8, e_kgs: 8};
        vecs[4] = '{upper: 24'd15, mask: 4'b1111, men: 1'b1, mkey: 24'd6, rst: 1'b1, go_mid: 1'b0,
                    e_found: 1'b1, e_core: 2'd2, e_fkey: 24'd6, e_issued: 24'd7, e_kgs: 8};
        vecs[5] = '{upper: 24'd15, mask: 4'b0110, men: 1'b1, mkey: 24'd3, rst: 1'b1, go_mid: 1'b0,
                    e_found: 1'b1, e_core: 2'd2, e_fkey: 24'd3, e_issued: 24'd4, e_kgs: 5};

        // reset state
        tick();
        tick();
        check("reset_outputs", {core_grant, core_key, kg_start, core_abort, busy, found,
                                exhausted, found_key, found_core, keys_issued}, 128'd0);
        reset_n = 1'b1;
        tick();

        // table-driven whole searches with free-running cores
        for (int v = 0; v < 6; v++) begin
            man_mode  = 1'b0;
            req_mask  = vecs[v].mask;
            match_en  = vecs[v].men;
            match_key = vecs[v].mkey;
            gen_lower = 24'd0;
            gen_upper = vecs[v].upper;
            if (vecs[v].rst) do_reset();
            bits.delete();
            for (int i = 0; i < 4; i++) if (vecs[v].mask[i]) bits.push_back(i);
            n_grants = vecs[v].men ? int'(vecs[v].mkey) + 1 : int'(vecs[v].upper) + 1;
            for (int k = 0; k < n_grants; k++)
                sb_q.push_back('{core: 2'(bits[k % bits.size()]), key: 24'(k)});
            kg_base = kg_starts;
            pulse_go();
            if (vecs[v].go_mid) begin
                tick();
                tick();
                check("busy_mid", {127'd0, busy}, 128'd1);
                pulse_go();
            end
            wait_status(2000);
            for (int k = 0; k < 6; k++) tick();
            check($sformatf("v%0d_found", v), {127'd0, found}, {127'd0, vecs[v].e_found});
            check($sformatf("v%0d_exhausted", v), {127'd0, exhausted}, {127'd0, !vecs[v].e_found});
            check($sformatf("v%0d_keys_issued", v), keys_issued, vecs[v].e_issued);
            check($sformatf("v%0d_kg_starts", v), kg_starts - kg_base, vecs[v].e_kgs);
            check($sformatf("v%0d_abort", v), {126'd0, core_abort, busy}, 128'd2);
            check($sformatf("v%0d_grants_left", v), sb_q.size(), 128'd0);
            if (vecs[v].e_found) begin
                check($sformatf("v%0d_found_core", v), found_core, vecs[v].e_core);
                check($sformatf("v%0d_found_key", v), found_key, vecs[v].e_fkey);
            end
        end

        // match on core 2 while cores 0 and 1 still hold keys
        man_mode  = 1'b1;
        m_req     = 4'b0111;
        m_done    = 4'b0000;
        m_match   = 4'b0000;
        gen_lower = 24'h000008;
        gen_upper = 24'h0000FF;
        do_reset();
        sb_q.push_back('{core: 2'd0, key: 24'h000008});
        sb_q.push_back('{core: 2'd1, key: 24'h000009});
        sb_q.push_back('{core: 2'd2, key: 24'h00000A});
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_to_kg_start", {127'd0, kg_start}, 128'd1);
        wait_sb_empty(200);
        for (int k = 0; k < 5; k++) tick();
        check("pre_match", {126'd0, busy, found}, 128'd2);
        m_done  = 4'b0100;
        m_match = 4'b0100;
        tick();
        m_done  = 4'b0000;
        m_match = 4'b0000;
        check("match_found", {127'd0, found}, 128'd1);
        check("match_key", found_key, 128'h00000A);
        check("match_core", found_core, 128'd2);
        check("match_abort", {126'd0, core_abort, busy}, 128'd2);
        kg_base = kg_starts;
        for (int k = 0; k < 12; k++) tick();
        check("no_kg_after_found", kg_starts - kg_base, 128'd0);

        // simultaneous matches on cores 1 and 3: lowest index wins
        m_req     = 4'b1111;
        gen_lower = 24'h000020;
        do_reset();
        for (int k = 0; k < 4; k++) sb_q.push_back('{core: 2'(k), key: 24'h000020 + 24'(k)});
        pulse_go();
        wait_sb_empty(200);
        for (int k = 0; k < 5; k++) tick();
        m_done  = 4'b1010;
        m_match = 4'b1010;
        tick();
        m_done  = 4'b0000;
        m_match = 4'b0000;
        check("tie_found_core", found_core, 128'd1);
        check("tie_found_key", found_key, 128'h000021);

        // reset while waiting on the generator with two keys outstanding
        m_req     = 4'b0011;
        gen_lower = 24'd0;
        do_reset();
        sb_q.push_back('{core: 2'd0, key: 24'd0});
        sb_q.push_back('{core: 2'd1, key: 24'd1});
        pulse_go();
        wait_sb_empty(200);
        tick();
        check("pre_reset_busy", {127'd0, busy}, 128'd1);
        reset_n = 1'b0;
        tick();
        check("midrun_reset_outputs", {core_grant, core_key, kg_start, core_abort, busy, found,
                                       exhausted, found_key, found_core, keys_issued}, 128'd0);
        reset_n = 1'b1;
        tick();
        m_req = 4'b0001;
        sb_q.push_back('{core: 2'd0, key: 24'd0});
        pulse_go();
        wait_sb_empty(200);
        for (int k = 0; k < 8; k++) tick();
        check("restart_issued", keys_issued, 128'd1);
        check("restart_busy", {127'd0, busy}, 128'd1);

        $display("%0d/%0d checks passed", passes + sb_passes, checks + sb_checks);
        $finish;
    end

endmodule
